// File: rtl/out_fm_st_ctrl_pkg.sv
// Shared definitions for the output feature-map store sequencer:
// FSM encoding, default widths and the outstanding-burst counter width.
package out_fm_st_ctrl_pkg;

  localparam int CW_DEF      = 16;
  localparam int AW_DEF      = 32;
  localparam int BW_DEF      = 12;
  localparam int MAX_OUT_DEF = 4;
  // MAX_OUT is bounded to 15 so a 4-bit outstanding count can never wrap
  localparam int OUT_W       = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } st_state_e;

endpackage

// File: rtl/out_fm_st_ctrl_if.sv
// Tile-store command channel plus burst write port of the store sequencer.
// master = the sequencer side, slave = the command source / memory side.
interface out_fm_st_ctrl_if import out_fm_st_ctrl_pkg::*; #(
  parameter int CW = CW_DEF,
  parameter int AW = AW_DEF,
  parameter int BW = BW_DEF
);
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_base;
  logic          st_buf_sel;
  logic [CW-1:0] n_rows;
  logic [CW-1:0] n_bursts;
  logic [CW-1:0] burst_len;
  logic [AW-1:0] row_stride;
  logic          wr_req;
  logic          wr_ack;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_len;
  logic [BW-1:0] wr_buf_addr;
  logic          wr_buf_sel;
  logic          wr_resp;

  modport master (
    input  st_valid, st_base, st_buf_sel, n_rows, n_bursts, burst_len, row_stride,
    input  wr_ack, wr_resp,
    output st_ready, wr_req, wr_addr, wr_len, wr_buf_addr, wr_buf_sel
  );

  modport slave (
    output st_valid, st_base, st_buf_sel, n_rows, n_bursts, burst_len, row_stride,
    output wr_ack, wr_resp,
    input  st_ready, wr_req, wr_addr, wr_len, wr_buf_addr, wr_buf_sel
  );

endinterface

// File: rtl/out_fm_st_ctrl_st_nest2_cnt.sv
// Two-level row / segment counter walking n_rows x n_bursts bursts of a tile.
// Equality compares make the full 2^CW-1 range usable.
module out_fm_st_ctrl_st_nest2_cnt import out_fm_st_ctrl_pkg::*; #(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  input  logic [CW-1:0] n_rows,
  input  logic [CW-1:0] n_bursts,
  output logic          last_seg,
  output logic          last_burst
);

  logic [CW-1:0] cnt_seg;
  logic [CW-1:0] cnt_row;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_seg <= '0;
      cnt_row <= '0;
    end else if (load) begin
      cnt_seg <= '0;
      cnt_row <= '0;
    end else if (inc) begin
      if (last_seg) begin
        cnt_seg <= '0;
        cnt_row <= cnt_row + CW'(1);
      end else begin
        cnt_seg <= cnt_seg + CW'(1);
      end
    end
  end

  assign last_seg   = (cnt_seg == n_bursts - CW'(1));
  assign last_burst = last_seg && (cnt_row == n_rows - CW'(1));

endmodule

// File: rtl/out_fm_st_ctrl.sv
// Store-side sequencer: walks a tile as rows x bursts, issues burst writes,
// tracks outstanding bursts and pulses tile_done once the tile is fully written.
module out_fm_st_ctrl import out_fm_st_ctrl_pkg::*; #(
  parameter int CW      = CW_DEF,
  parameter int AW      = AW_DEF,
  parameter int BW      = BW_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  out_fm_st_ctrl_if.master bus,
  output logic             busy,
  output logic             tile_done,
  output logic             done_buf_sel
);

  st_state_e      state, state_nx;
  logic [CW-1:0]  c_rows, c_bursts, c_len;
  logic [AW-1:0]  c_base, c_stride;
  logic           c_sel;
  logic [CW-1:0]  p_rows, p_bursts, p_len;
  logic [AW-1:0]  p_base, p_stride;
  logic           p_sel;
  logic           pend_full;
  logic [AW-1:0]  row_addr, seg_addr;
  logic [BW-1:0]  buf_off;
  logic [OUT_W-1:0] outs;
  logic           wr_req, fin, accept, take_in, fill_pend, pend_pop, ack, resp_dec;
  logic           last_seg, last_burst;

  // An accept while IDLE, or during FIN with nothing pending, starts the next tile directly
  assign accept    = bus.st_valid && bus.st_ready;
  assign take_in   = accept && (state == S_IDLE || state == S_FIN);
  assign fill_pend = accept && !take_in;
  assign pend_pop  = (state == S_FIN) && pend_full;
  assign ack       = wr_req && bus.wr_ack;
  assign resp_dec  = bus.wr_resp && (outs != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_LOAD;
      S_LOAD:  state_nx = (c_rows == '0 || c_bursts == '0) ? S_FIN : S_ISSUE;
      S_ISSUE: if (ack && last_burst) state_nx = S_DRAIN;
      S_DRAIN: if (outs == '0) state_nx = S_FIN;
      S_FIN:   state_nx = (pend_full || accept) ? S_LOAD : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    wr_req = 1'b0;
    busy   = 1'b1;
    fin    = 1'b0;
    case (state)
      S_IDLE:  busy   = 1'b0;
      S_ISSUE: wr_req = (outs < OUT_W'(MAX_OUT));
      S_FIN:   fin    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_full    <= 1'b0;
      outs         <= '0;
      tile_done    <= 1'b0;
      done_buf_sel <= 1'b0;
    end else begin
      if (fill_pend)     pend_full <= 1'b1;
      else if (pend_pop) pend_full <= 1'b0;
      if (ack && !resp_dec)      outs <= outs + OUT_W'(1);
      else if (!ack && resp_dec) outs <= outs - OUT_W'(1);
      tile_done    <= fin;
      done_buf_sel <= fin && c_sel;
    end
  end

  // Tile configuration: sampled only at accept, never reset (qualified by state)
  always_ff @(posedge clk) begin
    if (take_in) begin
      c_base <= bus.st_base;  c_sel    <= bus.st_buf_sel; c_rows <= bus.n_rows;
      c_bursts <= bus.n_bursts; c_len  <= bus.burst_len;  c_stride <= bus.row_stride;
    end else if (pend_pop) begin
      c_base <= p_base;  c_sel    <= p_sel; c_rows <= p_rows;
      c_bursts <= p_bursts; c_len <= p_len; c_stride <= p_stride;
    end
    if (fill_pend) begin
      p_base <= bus.st_base;  p_sel    <= bus.st_buf_sel; p_rows <= bus.n_rows;
      p_bursts <= bus.n_bursts; p_len  <= bus.burst_len;  p_stride <= bus.row_stride;
    end
  end

  // Address accumulators wrap modulo 2^AW / 2^BW
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      row_addr <= c_base;
      seg_addr <= c_base;
      buf_off  <= '0;
    end else if (ack) begin
      buf_off <= buf_off + BW'(c_len);
      if (last_seg) begin
        row_addr <= row_addr + c_stride;
        seg_addr <= row_addr + c_stride;
      end else begin
        seg_addr <= seg_addr + AW'(c_len);
      end
    end
  end

  out_fm_st_ctrl_st_nest2_cnt #(.CW(CW)) u_st_nest2_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (state == S_LOAD),
    .inc        (ack),
    .n_rows     (c_rows),
    .n_bursts   (c_bursts),
    .last_seg   (last_seg),
    .last_burst (last_burst)
  );

  assign bus.st_ready    = rst && !pend_full;
  assign bus.wr_req      = wr_req;
  assign bus.wr_addr     = wr_req ? seg_addr : '0;
  assign bus.wr_len      = wr_req ? c_len : '0;
  assign bus.wr_buf_addr = wr_req ? buf_off : '0;
  assign bus.wr_buf_sel  = wr_req && c_sel;

endmodule

// File: tb/tb_out_fm_st_ctrl.sv
// Self-checking bench for out_fm_st_ctrl: directed scenarios plus random tiles
// checked against a burst-list / outstanding-count reference model.
module tb_out_fm_st_ctrl;
  import out_fm_st_ctrl_pkg::*;

  localparam int CW = 16;
  localparam int AW = 32;
  localparam int BW = 12;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, tile_done, done_buf_sel;

  out_fm_st_ctrl_if #(.CW(CW), .AW(AW), .BW(BW)) bus ();

  out_fm_st_ctrl #(.CW(CW), .AW(AW), .BW(BW), .MAX_OUT(MAXO)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .tile_done    (tile_done),
    .done_buf_sel (done_buf_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] len;
    logic [BW-1:0] boff;
    logic          sel;
  } burst_t;

  burst_t exp_q[$];
  logic   exp_done_q[$];
  int     due_q[$];
  burst_t e;
  int nchk = 0, nerr = 0, cyc = 0, outs_m = 0, n_ack = 0, n_done = 0;
  int man_req = 0, man_done = 0, resp_dly = 2;
  bit resp_auto = 1'b0, resp_rand = 1'b0, ack_rand = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Responder: auto responses from the due list, or manual pulses requested by the main flow
  initial forever begin
    @(negedge clk);
    cyc++;
    bus.wr_resp = 1'b0;
    if (man_req != man_done) begin
      bus.wr_resp = 1'b1;
      man_done++;
    end else if (resp_auto && due_q.size() > 0 && due_q[0] <= cyc) begin
      bus.wr_resp = 1'b1;
      void'(due_q.pop_front());
    end
  end

  // Monitor: sampled between the input drive point and the next rising edge
  initial forever begin
    int o;
    @(negedge clk);
    #2;
    if (!rst) begin
      outs_m = 0;
      due_q.delete();
      exp_q.delete();
      exp_done_q.delete();
    end else begin
      if (tile_done) begin
        n_done++;
        chk("done_expected", 64'(exp_done_q.size() > 0), 64'(1));
        if (exp_done_q.size() > 0) chk("done_buf_sel", 64'(done_buf_sel), 64'(exp_done_q.pop_front()));
        chk("done_outs_zero", 64'(outs_m), 64'(0));
      end
      if (bus.wr_req) chk("outs_limit", 64'(outs_m < MAXO), 64'(1));
      o = outs_m;
      if (bus.wr_req && bus.wr_ack) begin
        n_ack++;
        o++;
        chk("burst_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
          chk("wr_len", 64'(bus.wr_len), 64'(e.len));
          chk("wr_buf_addr", 64'(bus.wr_buf_addr), 64'(e.boff));
          chk("wr_buf_sel", 64'(bus.wr_buf_sel), 64'(e.sel));
        end
        if (resp_auto) due_q.push_back(cyc + (resp_rand ? int'($urandom_range(4, 1)) : resp_dly));
      end
      if (bus.wr_resp && outs_m > 0) o--;
      outs_m = o;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
    if (ack_rand) bus.wr_ack = ($urandom % 4) != 0;
  endtask

  task automatic send_cmd(input logic [AW-1:0] base, input logic sel, input int rows,
                          input int bursts, input int len, input logic [AW-1:0] stride,
                          output int acc);
    int w = 0;
    burst_t b;
    while (!bus.st_ready && w < 2000) begin step(); w++; end
    chk("cmd_ready_wait", 64'(bus.st_ready), 64'(1));
    bus.st_valid = 1'b1;  bus.st_base = base;  bus.st_buf_sel = sel;
    bus.n_rows = CW'(rows); bus.n_bursts = CW'(bursts);
    bus.burst_len = CW'(len); bus.row_stride = stride;
    acc = cyc;
    for (int r = 0; r < rows; r++)
      for (int k = 0; k < bursts; k++) begin
        b.addr = base + stride * AW'(r) + AW'(k) * AW'(len);
        b.len  = CW'(len);
        b.boff = BW'((r * bursts + k) * len);
        b.sel  = sel;
        exp_q.push_back(b);
      end
    exp_done_q.push_back(sel);
    step();
    // Scramble the config inputs: only the value at accept may matter
    bus.st_valid = 1'b0;  bus.st_base = $urandom;  bus.st_buf_sel = 1'($urandom);
    bus.n_rows = CW'($urandom); bus.n_bursts = CW'($urandom);
    bus.burst_len = CW'($urandom); bus.row_stride = $urandom;
  endtask

  task automatic wait_done(input string tag, input int maxc, output int at);
    int k = 0;
    at = -1;
    do begin step(); k++; end while (!tile_done && k < maxc);
    chk(tag, 64'(tile_done), 64'(1));
    if (tile_done) at = cyc;
  endtask

  initial begin
    int acc, at, n0, d0, k;
    bus.st_valid = 1'b0; bus.st_base = '0; bus.st_buf_sel = 1'b0; bus.n_rows = '0;
    bus.n_bursts = '0; bus.burst_len = '0; bus.row_stride = '0; bus.wr_ack = 1'b0;
    repeat (3) step();
    chk("rst_wr_req", 64'(bus.wr_req), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_tile_done", 64'(tile_done), 64'(0));
    chk("rst_st_ready", 64'(bus.st_ready), 64'(0));
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'(0));
    rst = 1'b1;
    step();
    chk("idle_st_ready", 64'(bus.st_ready), 64'(1));

    // Basic tile, ack tied high, response two cycles after each ack
    resp_auto = 1'b1; resp_dly = 2; bus.wr_ack = 1'b1;
    send_cmd(32'h1000, 1'b0, 2, 3, 16, 32'h100, acc);
    wait_done("t1_done", 200, at);
    chk("t1_bursts_left", 64'(exp_q.size()), 64'(0));
    step();
    chk("t1_idle", 64'(busy), 64'(0));

    // Back-pressure: responses withheld
    resp_auto = 1'b0; n0 = n_ack;
    send_cmd(32'h2000, 1'b1, 1, 4, 8, 32'h40, acc);
    repeat (6) step();
    chk("t2_acks_capped", 64'(n_ack - n0), 64'(2));
    chk("t2_req_low", 64'(bus.wr_req), 64'(0));
    man_req++;
    repeat (4) step();
    chk("t2_one_more", 64'(n_ack - n0), 64'(3));
    chk("t2_req_low2", 64'(bus.wr_req), 64'(0));
    man_req++;
    repeat (4) step();
    chk("t2_all_issued", 64'(n_ack - n0), 64'(4));
    man_req += 2;
    wait_done("t2_done", 50, at);

    // Two queued tiles, back to back
    resp_auto = 1'b1;
    send_cmd(32'h3000, 1'b0, 1, 2, 4, 32'h10, acc);
    send_cmd(32'h4000, 1'b1, 1, 2, 4, 32'h10, acc);
    chk("t3_ready_low", 64'(bus.st_ready), 64'(0));
    wait_done("t3_done1", 100, at);
    chk("t3_sel1", 64'(done_buf_sel), 64'(0));
    chk("t3_busy_through", 64'(busy), 64'(1));
    chk("t3_ready_back", 64'(bus.st_ready), 64'(1));
    wait_done("t3_done2", 100, at);
    chk("t3_sel2", 64'(done_buf_sel), 64'(1));

    // Zero-size tiles
    send_cmd(32'h5000, 1'b1, 0, 3, 16, 32'h100, acc);
    wait_done("t4_done_rows0", 20, at);
    chk("t4_latency_rows0", 64'(at - acc), 64'(3));
    send_cmd(32'h5000, 1'b0, 2, 0, 16, 32'h100, acc);
    wait_done("t4_done_bursts0", 20, at);
    chk("t4_latency_bursts0", 64'(at - acc), 64'(3));

    // Same-cycle ack and response with one burst outstanding
    resp_auto = 1'b0; bus.wr_ack = 1'b0;
    send_cmd(32'h6000, 1'b1, 1, 2, 4, 32'h10, acc);
    k = 0;
    while (!bus.wr_req && k < 10) begin step(); k++; end
    chk("t5_req_up", 64'(bus.wr_req), 64'(1));
    bus.wr_ack = 1'b1;
    man_req++;
    step();
    step();
    bus.wr_ack = 1'b0;
    d0 = n_done;
    repeat (5) step();
    chk("t5_no_early_done", 64'(n_done - d0), 64'(0));
    chk("t5_busy_drain", 64'(busy), 64'(1));
    man_req++;
    wait_done("t5_done", 20, at);

    // Reset in the middle of a tile with a pending tile queued
    resp_auto = 1'b1; bus.wr_ack = 1'b1;
    send_cmd(32'h7000, 1'b0, 2, 3, 16, 32'h100, acc);
    send_cmd(32'h8000, 1'b1, 2, 3, 16, 32'h100, acc);
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("t6_wr_req", 64'(bus.wr_req), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_tile_done", 64'(tile_done), 64'(0));
    chk("t6_wr_addr", 64'(bus.wr_addr), 64'(0));
    repeat (2) step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_no_done", 64'(tile_done), 64'(0));
      chk("t6_idle", 64'(busy), 64'(0));
    end
    chk("t6_ready", 64'(bus.st_ready), 64'(1));

    // Random tiles with random ack and response timing
    ack_rand = 1'b1; resp_rand = 1'b1;
    for (int t = 0; t < 8; t++)
      send_cmd($urandom, 1'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(3, 1)),
               int'($urandom_range(3000, 1)), $urandom, acc);
    k = 0;
    while (exp_done_q.size() > 0 && k < 3000) begin step(); k++; end
    chk("t7_all_done", 64'(exp_done_q.size()), 64'(0));
    chk("t7_all_bursts", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
